rvfi_causal_window_check: RTL

// - Multi-channel RAW causality monitor on the RVFI trace.
// - Tracks one writer, selected by a symbolic insn order and register index.
// - Flags any younger instruction (order > writer) that reads that register and retires before the writer.
// - Generalises the single-channel causal check to NRET channels, configurable widths, sticky status and a retirement watchdog.
// - Sits beside the other rvfi_* checkers in the formal/sim harness.

---
 rtl/rvfi_causal_window_check.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rvfi_causal_window_check.sv
// rvfi_causal_window_check: multi-channel RAW causality monitor on the RVFI trace.
//
// One writer is tracked, selected by sym_order / sym_reg (held constant after reset).
// Any younger retirement (order > sym_order) that reads sym_reg before the writer
// retires taints the window; the writer then retiring with rd == sym_reg is a failure.
// Within one cycle, channels below the writer channel are "earlier" than the writer,
// channels above it are legal younger readers.
//
// Optional feature: define RVFI_CAUSAL_WAW_EN to also treat younger writers of
// sym_reg (WAW) as violations; they latch fail_cause[1]. Without the macro no WAW
// logic exists and fail_cause[1] stays 0.
//
// A watchdog counts cycles spent waiting for the writer (WAIT/TAINT) and raises a
// sticky timeout after TIMEOUT cycles. TIMEOUT == 0 disables it.

module rvfi_causal_window_check #(
  parameter int unsigned NRET     = 1,
  parameter int unsigned ORDER_W  = 64,
  parameter int unsigned REGIDX_W = 5,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]  rvfi_order,
  input  logic [NRET*REGIDX_W-1:0] rvfi_rs1_addr,
  input  logic [NRET*REGIDX_W-1:0] rvfi_rs2_addr,
  input  logic [NRET*REGIDX_W-1:0] rvfi_rd_addr,
  input  logic [ORDER_W-1:0]       sym_order,
  input  logic [REGIDX_W-1:0]      sym_reg,
  output logic [1:0]               state,
  output logic                     fail,
  output logic [1:0]               fail_cause,
  output logic                     vacuous,
  output logic                     timeout
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    StWait  = 2'b00,
    StTaint = 2'b01,
    StDone  = 2'b10,
    StFail  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            fail_q, fail_d;
  logic [1:0]      cause_q, cause_d;
  logic            vacuous_q, vacuous_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic                          reg_nz;
  logic [NRET-1:0]               raw;
  logic [NRET-1:0]               wr;
  logic [NRET-1:0][REGIDX_W-1:0] rd_ch;
`ifdef RVFI_CAUSAL_WAW_EN
  logic [NRET-1:0]               waw;
`endif

  // x0 is never a real dependency, so nothing can be violated against it
  assign reg_nz = (sym_reg != '0);

  for (genvar c = 0; c < NRET; c++) begin : g_ch
    logic [ORDER_W-1:0]  ord;
    logic [REGIDX_W-1:0] rs1;
    logic [REGIDX_W-1:0] rs2;
    logic                younger;

    assign ord      = rvfi_order[c*ORDER_W +: ORDER_W];
    assign rs1      = rvfi_rs1_addr[c*REGIDX_W +: REGIDX_W];
    assign rs2      = rvfi_rs2_addr[c*REGIDX_W +: REGIDX_W];
    assign rd_ch[c] = rvfi_rd_addr[c*REGIDX_W +: REGIDX_W];
    assign younger  = rvfi_valid[c] && (ord > sym_order);

    assign raw[c] = younger && reg_nz && ((rs1 == sym_reg) || (rs2 == sym_reg));
    assign wr[c]  = rvfi_valid[c] && (ord == sym_order);
`ifdef RVFI_CAUSAL_WAW_EN
    assign waw[c] = younger && reg_nz && (rd_ch[c] == sym_reg);
`endif
  end

  logic       wr_any;
  logic [REGIDX_W-1:0] wr_rd;
  logic       qual_raw;
  logic       qual_waw;
  logic       wr_match;
  logic [1:0] new_cause;

  // Pick the lowest writer channel; only violations on channels below it count
  always_comb begin
    wr_any   = 1'b0;
    wr_rd    = '0;
    qual_raw = 1'b0;
    qual_waw = 1'b0;
    for (int unsigned c = 0; c < NRET; c++) begin
      if (!wr_any) begin
        qual_raw = qual_raw | raw[c];
`ifdef RVFI_CAUSAL_WAW_EN
        qual_waw = qual_waw | waw[c];
`endif
        if (wr[c]) begin
          wr_any = 1'b1;
          wr_rd  = rd_ch[c];
        end
      end
    end
  end

  assign wr_match  = wr_any && reg_nz && (wr_rd == sym_reg);
  assign new_cause = {qual_waw, qual_raw};

  // Next-state for the window FSM, sticky status and watchdog
  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    cause_d   = cause_q;
    vacuous_d = vacuous_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StWait, StTaint: begin
        if (wr_any) begin
          if (!wr_match) begin
            // Writer does not produce sym_reg: property holds vacuously, taint dropped
            state_d   = StDone;
            vacuous_d = 1'b1;
          end else begin
            cause_d = cause_q | new_cause;
            if ((state_q == StTaint) || (new_cause != 2'b00)) begin
              state_d = StFail;
              fail_d  = 1'b1;
            end else begin
              state_d = StDone;
            end
          end
        end else if (new_cause != 2'b00) begin
          state_d = StTaint;
          cause_d = cause_q | new_cause;
        end
        if ((TIMEOUT != 0) && (cnt_q < TimeoutCnt)) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TimeoutCnt) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        // DONE / FAIL are terminal until reset
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StWait;
      fail_q    <= 1'b0;
      cause_q   <= 2'b00;
      vacuous_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      cause_q   <= cause_d;
      vacuous_q <= vacuous_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state      = state_q;
  assign fail       = fail_q;
  assign fail_cause = cause_q;
  assign vacuous    = vacuous_q;
  assign timeout    = timeout_q;

endmodule
